// File: rtl/x_event_packer.sv
// Event packer behind the row arbiter: validates grant/address, stamps each event
// with polarity and a free-running timestamp, and queues it in a first-word-fall-through FIFO.
module x_event_packer #(
    parameter int WIDTH    = 8,
    parameter int x_width  = 3,
    parameter int TS_WIDTH = 16,
    parameter int DEPTH    = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic [WIDTH-1:0]          x_gnt_i,
    input  logic [x_width-1:0]        xadd_i,
    input  logic                      pol_i,
    output logic                      evt_valid_o,
    output logic [TS_WIDTH+x_width:0] evt_data_o,
    input  logic                      evt_ready_i,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      full_o,
    output logic [7:0]                drop_cnt_o,
    output logic                      err_o
);

    localparam int PKT_W = TS_WIDTH + 1 + x_width;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]       CNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0]       PTR_ONE  = AW'(1);
    localparam logic [TS_WIDTH-1:0] TS_ONE   = TS_WIDTH'(1);
    localparam logic [WIDTH-1:0]    GNT_ONE  = WIDTH'(1);
    localparam logic [7:0]          DROP_MAX = 8'hFF;

    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [7:0]          drop_q, drop_d;
    logic                err_q, err_d;
    logic [PKT_W-1:0]    mem_q [DEPTH];
    logic [PKT_W-1:0]    mem_d [DEPTH];

    logic             cap;
    logic             evt_ok;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [PKT_W-1:0] pkt;

    function automatic logic is_onehot(input logic [WIDTH-1:0] g);
        return (g != '0) && ((g & (g - GNT_ONE)) == '0);
    endfunction

    always_comb begin
        cap    = enable_i & (|x_gnt_i);
        evt_ok = is_onehot(x_gnt_i) & x_gnt_i[xadd_i];
        full   = (count_q == CNT_FULL);
        pop    = (count_q != '0) & evt_ready_i;
        // A full FIFO still accepts the event when the head leaves in the same cycle.
        push   = cap & evt_ok & (~full | pop);
        drop   = cap & evt_ok & full & ~pop;
        pkt    = {ts_q, pol_i, xadd_i};

        ts_d     = enable_i ? (ts_q + TS_ONE) : ts_q;
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        drop_d = (drop && (drop_q != DROP_MAX)) ? (drop_q + 8'd1) : drop_q;
        err_d  = err_q | (cap & ~evt_ok);

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = pkt;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ts_q     <= ts_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
            mem_q    <= mem_d;
        end
    end

    // Head of the queue is shown directly, so a push is visible one cycle after capture.
    assign evt_valid_o = (count_q != '0);
    assign evt_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign full_o      = full;
    assign drop_cnt_o  = drop_q;
    assign err_o       = err_q;

endmodule
